// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DEC_RAM  = 2'd0,
        DEC_OUT  = 2'd1,
        DEC_NONE = 2'd2
    } dec_e;

    localparam logic M_CPU  = 1'b0;
    localparam logic M_LOAD = 1'b1;

    localparam logic [31:0] DEF_RAM_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_OUT_ADDR = 32'h1000_0000;

endpackage

// File: rtl/mem_bus_decode.sv
// Combinational address decoder: classifies a byte address as RAM window,
// output-byte register or unmapped, and gives the RAM word offset.
module mem_bus_decode
    import mem_bus_pkg::*;
#(
    parameter int          RAM_AW   = 10,
    parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
    parameter logic [31:0] OUT_ADDR = DEF_OUT_ADDR
) (
    input  logic [31:0]       addr_i,
    output dec_e              dec_o,
    output logic [RAM_AW-1:0] word_o
);

    localparam logic [32:0] RAM_BYTES = 33'd4 << RAM_AW;

    // 33-bit difference: bit 32 set means the address lies below the window
    logic [32:0] rel;

    assign rel    = {1'b0, addr_i} - {1'b0, RAM_BASE};
    assign word_o = rel[RAM_AW+1:2];

    always_comb begin
        dec_o = DEC_NONE;
        if (!rel[32] && (rel < RAM_BYTES)) begin
            dec_o = DEC_RAM;
        end else if (addr_i == OUT_ADDR) begin
            dec_o = DEC_OUT;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter/decoder sharing one 1-cycle-latency SRAM plus an output-byte
// register. Define MEM_ARB_CPU_PRIO_EN for fixed m0 priority instead of round robin.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int          RAM_AW   = 10,
    parameter logic [31:0] RAM_BASE = DEF_RAM_BASE,
    parameter logic [31:0] OUT_ADDR = DEF_OUT_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_valid,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    input  logic              m1_valid,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_we,
    input  logic [31:0]       ram_rdata,
    output logic [7:0]        out_byte,
    output logic              out_byte_en,
    output logic              bus_err
);

    state_e            state_q, state_d;
    logic              grant_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    dec_e              dec_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic              m0_ready_q, m1_ready_q;
    logic [31:0]       m0_rdata_q, m1_rdata_q;
    logic [7:0]        out_byte_q;
    logic              out_en_q, bus_err_q;
`ifndef MEM_ARB_CPU_PRIO_EN
    logic              last_grant_q;
`endif

    logic              req0, req1, req_any, sel;
    logic [31:0]       sel_addr, sel_wdata;
    logic [3:0]        sel_wstrb;
    dec_e              sel_dec;
    logic [RAM_AW-1:0] sel_word;
    logic [31:0]       resp_data;

    // A master in its ready cycle still shows valid; it must not be re-granted
    assign req0    = m0_valid & ~m0_ready_q;
    assign req1    = m1_valid & ~m1_ready_q;
    assign req_any = req0 | req1;

    always_comb begin
        sel = M_CPU;
`ifdef MEM_ARB_CPU_PRIO_EN
        if (!req0) sel = M_LOAD;
`else
        if (req0 && req1) sel = (last_grant_q == M_CPU) ? M_LOAD : M_CPU;
        else if (!req0)   sel = M_LOAD;
`endif
    end

    assign sel_addr  = (sel == M_LOAD) ? m1_addr  : m0_addr;
    assign sel_wdata = (sel == M_LOAD) ? m1_wdata : m0_wdata;
    assign sel_wstrb = (sel == M_LOAD) ? m1_wstrb : m0_wstrb;

    mem_bus_decode #(
        .RAM_AW   (RAM_AW),
        .RAM_BASE (RAM_BASE),
        .OUT_ADDR (OUT_ADDR)
    ) u_decode (
        .addr_i (sel_addr),
        .dec_o  (sel_dec),
        .word_o (sel_word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_any) state_d = (sel_dec == DEC_RAM) ? ISSUE : RESP;
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        resp_data = '0;
        case (dec_q)
            DEC_RAM: if (wstrb_q == 4'h0) resp_data = ram_rdata;
            DEC_OUT: if (wstrb_q == 4'h0) resp_data = {24'h0, out_byte_q};
            default: resp_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            out_byte_q   <= '0;
            out_en_q     <= 1'b0;
            bus_err_q    <= 1'b0;
`ifndef MEM_ARB_CPU_PRIO_EN
            last_grant_q <= M_LOAD;
`endif
        end else begin
            state_q    <= state_d;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            out_en_q   <= 1'b0;
            bus_err_q  <= 1'b0;
            if (state_q == IDLE && req_any) begin
`ifndef MEM_ARB_CPU_PRIO_EN
                last_grant_q <= sel;
`endif
                if (sel_dec == DEC_OUT && sel_wstrb != 4'h0) begin
                    out_byte_q <= sel_wdata[7:0];
                    out_en_q   <= 1'b1;
                end
                if (sel_dec == DEC_NONE) bus_err_q <= 1'b1;
            end
            if (state_q == RESP) begin
                if (grant_q == M_LOAD) begin
                    m1_ready_q <= 1'b1;
                    m1_rdata_q <= resp_data;
                end else begin
                    m0_ready_q <= 1'b1;
                    m0_rdata_q <= resp_data;
                end
            end
        end
    end

    // Transaction payload; only meaningful while the FSM is away from IDLE
    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_any) begin
            grant_q <= sel;
            wdata_q <= sel_wdata;
            wstrb_q <= sel_wstrb;
            dec_q   <= sel_dec;
            if (sel_dec == DEC_RAM) ram_addr_q <= sel_word;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = wdata_q;
    assign ram_we      = (state_q == ISSUE && !reset) ? wstrb_q : 4'h0;
    assign m0_ready    = m0_ready_q;
    assign m1_ready    = m1_ready_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;
    assign out_byte    = out_byte_q;
    assign out_byte_en = out_en_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized self-checking bench for mem_bus_arbiter with a transaction-level model.
module tb_mem_bus_arbiter;

    localparam logic [31:0] OUT_A     = 32'h1000_0000;
    localparam logic [31:0] RAM_BYTES = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;
    logic [7:0]  out_byte;
    logic        out_byte_en;
    logic        bus_err;

    mem_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .out_byte(out_byte), .out_byte_en(out_byte_en), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Byte-lane SRAM macro seen by the DUT
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        ram_rdata <= mem[ram_addr];
    end

    // Reference model state
    logic [31:0] shadow [0:1023];
    logic [7:0]  exp_out;
    int          lastg;

    logic [31:0] ta [2];
    logic [31:0] td [2];
    logic [3:0]  ts [2];
    bit          tv [2];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit in_ram(input logic [31:0] a);
        return a < RAM_BYTES;
    endfunction

    function automatic int lat(input logic [31:0] a);
        return in_ram(a) ? 3 : 2;
    endfunction

    task automatic model_access(input int m, output logic [31:0] r);
        logic [31:0] a;
        logic [9:0]  w;
        a = ta[m];
        w = a[11:2];
        r = '0;
        if (in_ram(a)) begin
            if (ts[m] == 4'h0) r = shadow[w];
            else
                for (int b = 0; b < 4; b++)
                    if (ts[m][b]) shadow[w][8*b +: 8] = td[m][8*b +: 8];
        end else if (a == OUT_A) begin
            if (ts[m] == 4'h0) r = {24'h0, exp_out};
            else exp_out = td[m][7:0];
        end
    endtask

    task automatic drive(input int m, input bit v);
        if (m == 0) begin
            m0_valid = v; m0_addr = ta[0]; m0_wdata = td[0]; m0_wstrb = ts[0];
        end else begin
            m1_valid = v; m1_addr = ta[1]; m1_wdata = td[1]; m1_wstrb = ts[1];
        end
    endtask

    // Issue up to one request per master in the same cycle and check both completions
    task automatic run_pair(input bit v0, input logic [31:0] a0, input logic [31:0] d0,
                            input logic [3:0] s0, input bit v1, input logic [31:0] a1,
                            input logic [31:0] d1, input logic [3:0] s1);
        int order[2];
        int expcyc[2];
        int nreq, ndone, cyc, cur, m;
        int we_n, be_n, oe_n, we_x, be_x, oe_x;
        logic rdy;
        logic [31:0] r, got;
        tv[0] = v0; ta[0] = a0; td[0] = d0; ts[0] = s0;
        tv[1] = v1; ta[1] = a1; td[1] = d1; ts[1] = s1;
        nreq = int'(v0) + int'(v1);
        if (nreq == 0) return;
        if (nreq == 2) begin
`ifdef MEM_ARB_CPU_PRIO_EN
            order[0] = 0;
`else
            order[0] = (lastg == 1) ? 0 : 1;
`endif
            order[1] = 1 - order[0];
        end else begin
            order[0] = v0 ? 0 : 1;
            order[1] = order[0];
        end
        expcyc[0] = lat(ta[order[0]]);
        expcyc[1] = expcyc[0] + lat(ta[order[1]]);
        we_x = 0; be_x = 0; oe_x = 0;
        for (int i = 0; i < nreq; i++) begin
            m = order[i];
            if (in_ram(ta[m])) we_x += (ts[m] != 0) ? 1 : 0;
            else if (ta[m] == OUT_A) oe_x += (ts[m] != 0) ? 1 : 0;
            else be_x++;
        end
        drive(0, v0);
        drive(1, v1);
        we_n = 0; be_n = 0; oe_n = 0; ndone = 0; cyc = 0;
        while (ndone < nreq && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (ram_we != 4'h0) begin
                we_n++;
                cur = order[ndone];
                chk("ram_we", 32'(ram_we), 32'(ts[cur]));
                chk("ram_addr", 32'(ram_addr), 32'(ta[cur][11:2]));
                chk("ram_wdata", ram_wdata, td[cur]);
            end
            be_n += int'(bus_err);
            oe_n += int'(out_byte_en);
            for (int k = 0; k < 2; k++) begin
                rdy = (k == 0) ? m0_ready : m1_ready;
                got = (k == 0) ? m0_rdata : m1_rdata;
                if (rdy) begin
                    if (!tv[k] || ndone >= nreq) begin
                        chk("spurious_ready", 32'(rdy), 32'd0);
                    end else begin
                        chk("grant_order", 32'(k), 32'(order[ndone]));
                        chk("latency", 32'(cyc), 32'(expcyc[ndone]));
                        model_access(k, r);
                        chk("rdata", got, r);
                        tv[k] = 1'b0;
                        drive(k, 1'b0);
                        ndone++;
                    end
                end
            end
        end
        if (ndone < nreq) begin
            chk("timeout", 32'(ndone), 32'(nreq));
            tv[0] = 0; tv[1] = 0;
            drive(0, 0); drive(1, 0);
        end
        lastg = order[nreq-1];
        chk("ram_we_count", 32'(we_n), 32'(we_x));
        chk("bus_err_count", 32'(be_n), 32'(be_x));
        chk("out_en_count", 32'(oe_n), 32'(oe_x));
        chk("out_byte", 32'(out_byte), 32'(exp_out));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int c;
        c = $urandom_range(0, 9);
        if (c <= 5) return {20'h0, 10'($urandom_range(0, 15)), 2'b00};
        if (c == 6) return {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        if (c == 7) return OUT_A;
        if (c == 8) return 32'h2000_0000 | {14'h0, 16'($urandom), 2'b00};
        return ($urandom_range(0, 1) == 0) ? RAM_BYTES : 32'hFFFF_FFFC;
    endfunction

    function automatic logic [3:0] rand_strb();
        return ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
    endfunction

    initial begin
        logic [31:0] v;
        bit          r0, r1;
        int          stuck;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            mem[i]    = v;
            shadow[i] = v;
        end
        exp_out = 8'h00;
        lastg   = 1;
        reset = 1'b1;
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_m0_ready", 32'(m0_ready), 32'd0);
        chk("rst_m1_ready", 32'(m1_ready), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_out_byte", 32'(out_byte), 32'd0);
        chk("rst_out_en", 32'(out_byte_en), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);

        // Simultaneous first requests: m0 wins the first tie, then alternation
        run_pair(1, 32'h0000_0020, 32'h1111_1111, 4'hF, 1, 32'h0000_0024, 32'h2222_2222, 4'hF);
        run_pair(1, 32'h0000_0020, 32'h0, 4'h0, 1, 32'h0000_0024, 32'h0, 4'h0);
        run_pair(1, 32'h0000_0028, 32'h3333_3333, 4'h3, 1, 32'h0000_0028, 32'h4444_4444, 4'hC);
        // Full-word write then readback
        run_pair(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0);
        run_pair(1, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 0, 0);
        // Output-byte register write and read
        run_pair(0, 0, 0, 0, 1, OUT_A, 32'h0000_0041, 4'h1);
        run_pair(1, OUT_A, 32'h0, 4'h0, 0, 0, 0, 0);
        // Single-lane write
        run_pair(1, 32'h0000_0008, 32'h1234_5678, 4'b0100, 0, 0, 0, 0);
        run_pair(1, 32'h0000_0008, 32'h0, 4'h0, 0, 0, 0, 0);
        // Unmapped and window-edge accesses
        run_pair(1, 32'h2000_0000, 32'h0, 4'h0, 0, 0, 0, 0);
        run_pair(1, 32'h0000_0FFC, 32'h5A5A_A5A5, 4'hF, 1, RAM_BYTES, 32'hFFFF_FFFF, 4'hF);
        run_pair(0, 0, 0, 0, 1, 32'h0000_0FFC, 32'h0, 4'h0);

        for (int it = 0; it < 80; it++) begin
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            run_pair(r0, rand_addr(), $urandom, rand_strb(), r1, rand_addr(), $urandom, rand_strb());
        end

        // Reset while a RAM write sits in ISSUE
        run_pair(1, OUT_A, 32'h0000_00A5, 4'hF, 0, 0, 0, 0);
        ta[0] = 32'h0000_0040; td[0] = 32'hCAFE_F00D; ts[0] = 4'hF;
        drive(0, 1'b1);
        @(posedge clk); #1;
        chk("issue_we", 32'(ram_we), 32'hF);
        reset = 1'b1;
        #1 chk("reset_cycle_we", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 1'b0);
        exp_out = 8'h00;
        lastg   = 1;
        chk("post_rst_out_byte", 32'(out_byte), 32'd0);
        stuck = 0;
        repeat (6) begin
            stuck += int'(m0_ready) + int'(ram_we != 4'h0);
            @(posedge clk); #1;
        end
        chk("post_rst_activity", 32'(stuck), 32'd0);
        run_pair(1, 32'h0000_0040, 32'h0, 4'h0, 0, 0, 0, 0);
        run_pair(1, 32'h0000_0044, 32'h0, 4'h0, 1, 32'h0000_0048, 32'h0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master arbiter and address decoder for the picorv32-style native memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Shares one single-port, 32-bit, byte-write-enabled synchronous SRAM (1-cycle read latency) between the CPU core (m0) and a second master (m1: program loader/DMA).
- Also owns the memory-mapped output-byte register.
- Sits between the core, the loader and the four byte-lane RAM macros in the system top.

Parameters:
- RAM_AW, 10, RAM word-address width (RAM holds 2^RAM_AW 32-bit words).
- RAM_BASE, 32'h0000_0000, byte base address of RAM window (window = RAM_BASE .. RAM_BASE + 4*2^RAM_AW - 1).
- OUT_ADDR, 32'h1000_0000, byte address of output-byte register.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- m0_valid/m1_valid  in  1  master request
- m0_addr/m1_addr  in  32  byte address
- m0_wdata/m1_wdata  in  32  write data
- m0_wstrb/m1_wstrb  in  4  byte strobes; 0 = read
- m0_ready/m1_ready  out  1  one-cycle completion pulse
- m0_rdata/m1_rdata  out  32  read data, valid when ready=1
- ram_addr  out  RAM_AW  word address (addr[RAM_AW+1:2] - base)
- ram_wdata  out  32  RAM write data
- ram_we  out  4  per-byte-lane write enable
- ram_rdata  in  32  RAM read data, valid the cycle after address
- out_byte  out  8  last byte written to OUT_ADDR
- out_byte_en  out  1  one-cycle strobe on OUT_ADDR write
- bus_err  out  1  one-cycle pulse on unmapped access

Behaviour:
- Reset: FSM=IDLE, last_grant=1 (m0 wins the first tie). m*_ready=0, m*_rdata=0, ram_we=0, out_byte=0, out_byte_en=0, bus_err=0.
- Reset mid-transaction: drop the transaction, no ready issued, no RAM write in the reset cycle or after.
- FSM states IDLE, ISSUE, RESP.
- IDLE:
  - If any valid, pick grant: only one valid → that one; both valid → the master not equal to last_grant (round robin).
  - Latch addr/wdata/wstrb; update last_grant.
  - RAM-window hit → ISSUE.
  - Write to OUT_ADDR → RESP; out_byte <= wdata[7:0], out_byte_en=1 for one cycle. Strobes ignored.
  - Read of OUT_ADDR → RESP, rdata = {24'b0, out_byte}.
  - Any other address → RESP, rdata=0, writes discarded, bus_err=1 for one cycle.
- ISSUE:
  - Drive ram_addr; ram_we=latched wstrb for exactly this cycle; ram_wdata=latched wdata → RESP.
- RESP:
  - Granted master's ready=1 for one cycle.
  - rdata = ram_rdata for a RAM read; 0 for a RAM write.
  - Non-granted master's ready stays 0 → IDLE.
- Latency (valid to ready): RAM access 3 cycles; MMIO/unmapped 2 cycles.
- Fairness: the next IDLE after RESP re-arbitrates. The granted master has dropped valid after ready, so a waiting master is granted next; waits are bounded at one transaction.
- Masters hold valid/addr/wdata/wstrb stable until ready; the arbiter samples only in IDLE.
- ram_addr holds its last value when idle; ram_we=0 outside ISSUE.

Optional Feature:
- Macro MEM_ARB_CPU_PRIO_EN.
- Defined: fixed priority, m0 always wins when both valid; last_grant is unused.
- Undefined: round robin as above.
- All other behaviour is identical.

Decomposition:
- Shared package mem_bus_pkg:
  - FSM state enum (IDLE/ISSUE/RESP)
  - master-id constants M_CPU=0, M_LOAD=1
  - default OUT_ADDR and RAM_BASE constants
  - addr-decode result enum (DEC_RAM/DEC_OUT/DEC_NONE)
- One natural sub-module: mem_bus_decode, a combinational address → decode class with RAM word offset.
- The arbiter FSM and output muxing stay in the top.

Test Plan:
- m0 writes 0xDEADBEEF, wstrb=4'hF, to 0x0000_0010, then reads it back → ram_we=4'hF with ram_addr=4 in ISSUE; read ready 3 cycles after valid, m0_rdata=0xDEADBEEF.
- m0 and m1 assert valid on the same cycle after reset → m0 served first; m1_ready 3 cycles after m0_ready. Repeated simultaneous requests alternate grants. With MEM_ARB_CPU_PRIO_EN, m0 is always served first.
- m1 writes 0x0000_0041 to 0x1000_0000 → out_byte=0x41, out_byte_en=1 for one cycle; m1_ready 2 cycles after valid; ram_we never nonzero.
- m0 writes 0x12345678, wstrb=4'b0100, to 0x8 → only lane 2 written; readback returns the old word with byte 2 = 0x34.
- m0 reads 0x2000_0000 → m0_rdata=0, bus_err pulse, m0_ready after 2 cycles, no RAM write.
- Assert reset during ISSUE of a write → ram_we=0 from the reset cycle on, no ready issued, FSM in IDLE, out_byte=0.
